// File: rtl/regfile_alu_sequencer_if.sv
// Command and response bundle between a command master and the register-bank ALU sequencer.
interface regfile_alu_sequencer_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic [DW-1:0] cmd_imm;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero;
  logic          rsp_carry;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry
  );
endinterface

// File: rtl/regfile_alu_sequencer.sv
// Single-command ALU sequencer: reads two bank registers, computes, writes back and responds,
// then holds off new commands until the bank's delayed write is visible.
module regfile_alu_sequencer #(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 3,
  parameter int unsigned WB_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_alu_sequencer_if.slave io_cmd,
  output logic [AW-1:0]          o_ra1,
  output logic [AW-1:0]          o_ra2,
  input  logic [DW-1:0]          i_rd1,
  input  logic [DW-1:0]          i_rd2,
  output logic                   o_we,
  output logic [AW-1:0]          o_wa,
  output logic [DW-1:0]          o_wd
);
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRead   = 3'd1,
    StExec   = 3'd2,
    StWrite  = 3'd3,
    StSettle = 3'd4
  } state_e;

  state_e        r_state, w_state_next;
  logic [2:0]    r_op;
  logic [AW-1:0] r_rd, r_ra1, r_ra2, r_wa;
  logic [DW-1:0] r_imm, r_a, r_b, r_wd, r_rsp_data;
  logic          r_we, r_rsp_valid, r_rsp_zero, r_rsp_carry;
  logic [2:0]    r_cnt;
  logic          w_accept;
  logic [DW:0]   w_sum;
  logic [DW-1:0] w_res;
  logic          w_carry;

  assign io_cmd.cmd_ready = (r_state == StIdle) && !rst;
  assign w_accept         = io_cmd.cmd_valid && io_cmd.cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = StIdle;
    case (r_state)
      StIdle:   w_state_next = w_accept ? StRead : StIdle;
      StRead:   w_state_next = StExec;
      StExec:   w_state_next = StWrite;
      StWrite:  w_state_next = (WB_LAT > 0) ? StSettle : StIdle;
      StSettle: w_state_next = (r_cnt == 3'd0) ? StIdle : StSettle;
      default:  w_state_next = StIdle;
    endcase
  end

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    case (r_op)
      3'b000: begin
        w_res   = w_sum[DW-1:0];
        w_carry = w_sum[DW];
      end
      3'b001: begin
        w_res   = r_a - r_b;
        w_carry = (r_a < r_b);
      end
      3'b010:  w_res = r_a & r_b;
      3'b011:  w_res = r_a | r_b;
      3'b100:  w_res = r_a ^ r_b;
      3'b101:  w_res = r_a << r_b[2:0];
      3'b110:  w_res = r_a >> r_b[2:0];
      default: w_res = r_imm;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= '0;
      r_rd        <= '0;
      r_imm       <= '0;
      r_ra1       <= '0;
      r_ra2       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_we        <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_carry <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_we        <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_op  <= io_cmd.cmd_op;
            r_rd  <= io_cmd.cmd_rd;
            r_imm <= io_cmd.cmd_imm;
            r_ra1 <= io_cmd.cmd_rs1;
            r_ra2 <= io_cmd.cmd_rs2;
          end
        end
        StRead: begin
          r_a <= i_rd1;
          r_b <= i_rd2;
        end
        StExec: begin
          r_wa        <= r_rd;
          r_wd        <= w_res;
          r_rsp_data  <= w_res;
          r_rsp_zero  <= (w_res == '0);
          r_rsp_carry <= w_carry;
          r_we        <= (r_rd != '0);  // x0 is hardwired; never write it
          r_rsp_valid <= 1'b1;
        end
        StWrite: begin
          if (WB_LAT > 0) r_cnt <= 3'(WB_LAT - 1);
        end
        StSettle: begin
          if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_ra1            = r_ra1;
  assign o_ra2            = r_ra2;
  assign o_we             = r_we;
  assign o_wa             = r_wa;
  assign o_wd             = r_wd;
  assign io_cmd.rsp_valid = r_rsp_valid;
  assign io_cmd.rsp_data  = r_rsp_data;
  assign io_cmd.rsp_zero  = r_rsp_zero;
  assign io_cmd.rsp_carry = r_rsp_carry;
endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Randomised scoreboard bench for regfile_alu_sequencer with a delayed-visibility bank model.
module tb_regfile_alu_sequencer;
  localparam int WB_LAT = 2;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_LDI = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_alu_sequencer_if bus ();
  logic [2:0] ra1, ra2, wa;
  logic [7:0] rd1, rd2, wd;
  logic       we;

  regfile_alu_sequencer #(.DW(8), .AW(3), .WB_LAT(WB_LAT)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_cmd (bus),
    .o_ra1  (ra1),
    .o_ra2  (ra2),
    .i_rd1  (rd1),
    .i_rd2  (rd2),
    .o_we   (we),
    .o_wa   (wa),
    .o_wd   (wd)
  );

  // Bank: a write becomes readable only after the second rising edge.
  logic [7:0] bank [8] = '{default: 8'h00};
  logic       pend_v = 1'b0;
  logic [2:0] pend_a = 3'd0;
  logic [7:0] pend_d = 8'd0;
  always @(posedge clk) begin
    pend_v <= we;
    pend_a <= wa;
    pend_d <= wd;
    if (pend_v && pend_a != 3'd0) bank[pend_a] <= pend_d;
  end
  assign rd1 = bank[ra1];
  assign rd2 = bank[ra2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         data;
    bit         zero;
    bit         carry;
    logic [2:0] rd;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   ref_regs[8] = '{default: 0};
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_acc = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void model(input logic [2:0] op, input int a, input int b, input int imm,
                                output int res, output bit c);
    c = 1'b0;
    case (op)
      OP_ADD: begin res = (a + b) % 256; c = (a + b) > 255; end
      OP_SUB: begin res = (a - b + 256) % 256; c = a < b; end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SLL: res = (a * (1 << (b % 8))) % 256;
      OP_SRL: res = a / (1 << (b % 8));
      default: res = imm;
    endcase
  endfunction

  task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic [7:0] imm, input bit hold,
                      input bit spacing, input bit track);
    int   res;
    bit   c;
    bit   ok;
    exp_t e;
    @(negedge clk);
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got ready=0, expected ready=1 within 100 cycles");
      bus.cmd_valid = 1'b0;
      return;
    end
    if (spacing) chk("accept_spacing", cyc - last_acc, 4 + WB_LAT);
    last_acc = cyc;
    if (track) begin
      model(op, ref_regs[rs1], ref_regs[rs2], int'(imm), res, c);
      e.data  = res;
      e.zero  = (res == 0);
      e.carry = c;
      e.rd    = rd;
      e.acc   = cyc;
      exp_q.push_back(e);
      if (rd != 3'd0) ref_regs[rd] = res;
    end
    @(posedge clk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1, expected 0 (cycle %0d)", cyc);
        end else begin
          m_e = exp_q.pop_front();
          chk("rsp_data", int'(bus.rsp_data), m_e.data);
          chk("rsp_zero", int'(bus.rsp_zero), int'(m_e.zero));
          chk("rsp_carry", int'(bus.rsp_carry), int'(m_e.carry));
          chk("latency", cyc - m_e.acc, 3);
          chk("we", int'(we), int'(m_e.rd != 3'd0));
          if (m_e.rd != 3'd0) begin
            chk("wa", int'(wa), int'(m_e.rd));
            chk("wd", int'(wd), m_e.data);
          end
        end
      end else if (we) begin
        n_tests++;
        n_fail++;
        $display("FAIL we_without_rsp: got we=1, expected 0 (cycle %0d)", cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a command already asserted: reset must win.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_rd    = 3'd3;
    bus.cmd_rs1   = 3'd5;
    bus.cmd_rs2   = 3'd6;
    bus.cmd_imm   = 8'h00;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("ready_in_rst", int'(bus.cmd_ready), 0);
    end
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    chk("rst_ready", int'(bus.cmd_ready), 1);
    chk("rst_ra1", int'(ra1), 0);
    chk("rst_ra2", int'(ra2), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_wa", int'(wa), 0);
    chk("rst_wd", int'(wd), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_data", int'(bus.rsp_data), 0);
    chk("rst_rsp_zero", int'(bus.rsp_zero), 0);
    chk("rst_rsp_carry", int'(bus.rsp_carry), 0);

    send(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h7F, 0, 0, 1);
    send(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h01, 0, 0, 1);
    send(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00, 0, 0, 1);

    send(OP_LDI, 3'd4, 3'd0, 3'd0, 8'hFF, 0, 0, 1);
    send(OP_ADD, 3'd5, 3'd4, 3'd2, 8'h00, 0, 0, 1);
    send(OP_SUB, 3'd6, 3'd2, 3'd4, 8'h00, 0, 0, 1);
    send(OP_SUB, 3'd6, 3'd4, 3'd4, 8'h00, 0, 0, 1);

    send(OP_LDI, 3'd0, 3'd0, 3'd0, 8'h55, 0, 0, 1);
    send(OP_OR,  3'd7, 3'd0, 3'd0, 8'h00, 0, 0, 1);

    // Held cmd_valid: each accept must see the previous writeback.
    for (int i = 0; i < 4; i++) send(OP_ADD, 3'd3, 3'd3, 3'd2, 8'h00, i < 3, i > 0, 1);

    send(OP_SLL, 3'd7, 3'd1, 3'd2, 8'h00, 0, 0, 1);
    send(OP_LDI, 3'd5, 3'd0, 3'd0, 8'h07, 0, 0, 1);
    send(OP_SRL, 3'd6, 3'd4, 3'd5, 8'h00, 0, 0, 1);
    send(OP_XOR, 3'd6, 3'd4, 3'd1, 8'h00, 0, 0, 1);
    send(OP_LDI, 3'd1, 3'd0, 3'd0, 8'hF0, 0, 0, 1);
    send(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h3C, 0, 0, 1);
    send(OP_AND, 3'd3, 3'd1, 3'd2, 8'h00, 0, 0, 1);

    // Abort a command with reset during EXEC.
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    send(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", int'(bus.cmd_ready), 1);
    chk("abort_we", int'(we), 0);
    chk("abort_rsp_valid", int'(bus.rsp_valid), 0);
    chk("abort_ra1", int'(ra1), 0);
    chk("abort_wd", int'(wd), 0);
    chk("abort_rsp_data", int'(bus.rsp_data), 0);
    repeat (6) @(negedge clk);
    send(OP_LDI, 3'd4, 3'd0, 3'd0, 8'hA5, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      send(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom),
           1'($urandom), 0, 1);
    end
    bus.cmd_valid = 1'b0;

    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_alu_sequencer.md
Name: regfile_alu_sequencer

Overview:
Command-driven initiator for the 8-entry x 8-bit two-read/one-write register bank. It accepts one ALU command at a time on a valid/ready interface. For each command it reads the two source registers, computes an 8-bit result, writes the result back to the bank and returns it with flags. It is the bank's only master in the lab datapath and enforces the bank's write-to-read visibility delay.

Parameters:
DW, 8, data width; must match the bank word width.
AW, 3, register address width; 8 registers, x0 hardwired to zero.
WB_LAT, 2, cycles held in SETTLE after a writeback; covers the bank's two-edge write-to-read visibility. Legal range 0..7.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; synchronous, active-high.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command.
cmd_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 LDI.
cmd_rd  in  AW  destination register.
cmd_rs1  in  AW  source register 1.
cmd_rs2  in  AW  source register 2.
cmd_imm  in  DW  immediate; used by LDI only.
ra1  out  AW  bank read address 1.
ra2  out  AW  bank read address 2.
rd1  in  DW  bank read data 1; combinational from ra1.
rd2  in  DW  bank read data 2; combinational from ra2.
we  out  1  bank write enable.
wa  out  AW  bank write address.
wd  out  DW  bank write data.
rsp_valid  out  1  one-cycle result pulse.
rsp_data  out  DW  result.
rsp_zero  out  1  result == 0.
rsp_carry  out  1  ADD carry-out or SUB borrow; 0 for all other ops.

Behaviour:
- Outputs: all registered except cmd_ready, which is 1 only when state==IDLE and rst==0.
- Reset: with rst high at a clock edge, the next state is IDLE and ra1, ra2, we, wa, wd, rsp_* all become 0. Latched command and operand registers are also cleared.
- States:
  - IDLE -> READ on cmd_valid && cmd_ready. At that edge: latch op/rd/imm, set ra1=cmd_rs1, ra2=cmd_rs2.
  - READ: ra1/ra2 stable for the whole cycle. At its end, capture rd1/rd2 into operands A/B. Next state EXEC.
  - EXEC: compute the result into a register at the end of the cycle; load wa=rd, wd=result, rsp_data, rsp_zero, rsp_carry. Set we=(rd!=0) and rsp_valid=1. Next state WRITE.
  - WRITE: we and rsp_valid are high for exactly this one cycle; they drop at the next edge. Next state is SETTLE if WB_LAT>0, else IDLE.
  - SETTLE: a counter loaded with WB_LAT-1 decrements each cycle; go to IDLE when it reaches 0. cmd_ready is 0 throughout.
- Timing:
  - Latency: command accepted in cycle 0; rsp_valid and we in cycle 3.
  - Earliest next accept is cycle 4+WB_LAT, i.e. cycle 6 at default.
  - Back-to-back read-after-write therefore sees updated data without forwarding.
- Arithmetic, all DW-bit, unsigned, result wraps modulo 2^DW:
  - ADD: {carry,res}=A+B.
  - SUB: res=A-B; carry=(A<B).
  - SLL/SRL: shift A by B[2:0]; zeros shifted in.
  - AND/OR/XOR: bitwise.
  - LDI: res=imm; no dependency on rd1/rd2.
- Boundary conditions:
  - rd==0: we stays 0 for the entire command; the response is still returned with the computed value.
  - rs1==rs2: legal; both ports read the same register.
  - rs==rd: legal; the old value is used as the operand.
  - cmd_valid while not IDLE: ignored and not latched; the master must hold cmd_valid and the command fields stable until accepted.
  - rst mid-command (any state): abort with no we pulse and no rsp_valid. cmd_ready is 1 in the first cycle with rst low.
  - Simultaneous rst and cmd_valid: rst wins; no command is accepted.
- Unknown states decode to IDLE.

Test Plan:
1. Reset, then LDI x1=0x7F, LDI x2=0x01, ADD x3=x1+x2 -> each LDI gives one we pulse (wa=1/2, wd=0x7F/0x01). ADD gives wa=3, wd=0x80, rsp_data=0x80, zero=0, carry=0, with rsp_valid exactly 3 cycles after acceptance.
2. LDI x4=0xFF, ADD x5=x4+x2 -> wd=0x00, rsp_zero=1, rsp_carry=1. Then SUB x6=x2-x4 -> 0x02, carry=1. Then SUB x6=x4-x4 -> 0x00, zero=1, carry=0.
3. LDI x0=0x55 -> we stays 0 all command; rsp_data=0x55. Then OR x7=x0|x0 -> 0x00, zero=1.
4. cmd_valid held high with ADD x3=x3+x2 issued repeatedly -> accepts spaced exactly 6 cycles apart. Successive wd values are 0x81, 0x82, 0x83, proving the RAW result is visible.
5. SLL x1 by x2 (0x7F<<1) -> 0xFE. SRL x4 by a register holding 0x07 (0xFF>>7) -> 0x01. XOR x4^x1 -> 0x80. AND 0xF0&0x3C -> 0x30. All have carry=0.
6. Accept ADD, assert rst for one cycle during EXEC -> no we or rsp_valid pulse; all outputs 0; cmd_ready=1 the cycle after rst drops. The next LDI completes normally.
